// File: rtl/dog_pkg.sv
// Shared constants and read-FSM state type for the DoG ping-pong line buffer.
package dog_pkg;

    localparam int unsigned DOG_LINE_W = 256;
    localparam int unsigned DOG_AW     = 8;
    localparam int unsigned DOG_KERNEL = 5;
    localparam int unsigned DOG_PAD    = (DOG_KERNEL - 1) / 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } rd_state_e;

endpackage

// File: rtl/dog_bank_ram.sv
// One line bank: 1R1W RAM with a registered read port that returns 0 when not read.
module dog_bank_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Zero on idle cycles so the bank output doubles as the gated data port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= re_i ? mem_q[raddr_i] : '0;
        end
    end

endmodule

// File: rtl/dog_line_pingpong.sv
// Ping-pong line buffer: fills one bank while replaying the other, edge-padded,
// on bank-tagged valid/data pairs. Padding is enabled with `define DOG_PP_PAD_EN.
module dog_line_pingpong
    import dog_pkg::*;
#(
    parameter int unsigned LINE_W = DOG_LINE_W,
    parameter int unsigned AW     = DOG_AW,
    parameter int unsigned PAD    = DOG_PAD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       ram0_valid_out,
    output logic [7:0] ram0_data_out,
    output logic       ram1_valid_out,
    output logic [7:0] ram1_data_out,
    output logic       line_done
);

    localparam int unsigned PW = 8;
    localparam int unsigned CW = AW + 2;
`ifdef DOG_PP_PAD_EN
    localparam int unsigned N  = LINE_W + 2 * PAD;
`else
    localparam int unsigned N  = LINE_W;
`endif

    if (LINE_W != (32'd1 << AW)) begin : g_chk_line_w
        $error("dog_line_pingpong: LINE_W must equal 2**AW");
    end
    if (2 * PAD >= LINE_W) begin : g_chk_pad
        $error("dog_line_pingpong: PAD too large for LINE_W");
    end

    rd_state_e     state_q, state_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]    full_q, full_d;
    logic          wsel_q, wsel_d;
    logic          rsel_q, rsel_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          wr_ready_q;
    logic [1:0]    valid_q, valid_d;
    logic          line_done_q;

    logic          wr_accept_c;
    logic          rd_issue_c;
    logic          done_c;
    logic [AW-1:0] rd_addr_c;

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Read FSM next state; start aborts any replay in progress.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            IDLE: begin
                rd_cnt_d = '0;
                if (full_q[rsel_q]) state_d = READ;
            end
            READ: begin
                if (rd_cnt_q == CW'(N - 1)) state_d = DONE;
                else rd_cnt_d = rd_cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d  = IDLE;
            rd_cnt_d = '0;
        end
    end

`ifdef DOG_PP_PAD_EN
    logic signed [CW-1:0] rd_idx_c;
    assign rd_idx_c = $signed(rd_cnt_q) - $signed(CW'(PAD));
`endif

    // Read FSM outputs: issue strobe, clamped replay address, end-of-line clear.
    always_comb begin
        rd_issue_c = (state_q == READ) && !start;
        done_c     = (state_q == DONE) && !start;
`ifdef DOG_PP_PAD_EN
        if (rd_idx_c[CW-1]) begin
            rd_addr_c = '0;
        end else if (rd_idx_c > $signed(CW'(LINE_W - 1))) begin
            rd_addr_c = AW'(LINE_W - 1);
        end else begin
            rd_addr_c = rd_idx_c[AW-1:0];
        end
`else
        rd_addr_c = rd_cnt_q[AW-1:0];
`endif
    end

    // Bank flags and write pointer; a write completion and a DONE clear can coincide.
    always_comb begin
        full_d      = full_q;
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        wr_addr_d   = wr_addr_q;
        wr_accept_c = wr_valid && wr_ready_q && !start;
        if (wr_accept_c) begin
            if (wr_addr_q == AW'(LINE_W - 1)) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
                wr_addr_d      = '0;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
        if (done_c) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
        end
        if (start) begin
            full_d    = '0;
            wsel_d    = 1'b0;
            rsel_d    = 1'b0;
            wr_addr_d = '0;
        end
    end

    always_comb begin
        valid_d[0] = rd_issue_c && !rsel_q;
        valid_d[1] = rd_issue_c && rsel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_ready_q  <= 1'b1;
            valid_q     <= '0;
            line_done_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            wr_addr_q   <= wr_addr_d;
            wr_ready_q  <= !full_d[wsel_d];
            valid_q     <= valid_d;
            line_done_q <= done_c;
        end
    end

    dog_bank_ram #(.DEPTH(LINE_W), .AW(AW), .DW(PW)) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_accept_c && !wsel_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data),
        .re_i    (valid_d[0]),
        .raddr_i (rd_addr_c),
        .rdata_o (ram0_data_out)
    );

    dog_bank_ram #(.DEPTH(LINE_W), .AW(AW), .DW(PW)) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_accept_c && wsel_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data),
        .re_i    (valid_d[1]),
        .raddr_i (rd_addr_c),
        .rdata_o (ram1_data_out)
    );

    assign wr_ready       = wr_ready_q;
    assign ram0_valid_out = valid_q[0];
    assign ram1_valid_out = valid_q[1];
    assign line_done      = line_done_q;

endmodule

// File: tb/tb_dog_line_pingpong.sv
// Bench for dog_line_pingpong: directed and random writes checked against a line-queue model.
module tb_dog_line_pingpong;

    localparam int LINE_W = 256;
    localparam int AW     = 8;
    localparam int PAD    = 2;
`ifdef DOG_PP_PAD_EN
    localparam int N      = LINE_W + 2 * PAD;
`else
    localparam int N      = LINE_W;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       ram0_valid_out;
    logic [7:0] ram0_data_out;
    logic       ram1_valid_out;
    logic [7:0] ram1_data_out;
    logic       line_done;

    dog_line_pingpong #(.LINE_W(LINE_W), .AW(AW), .PAD(PAD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .ram0_valid_out (ram0_valid_out),
        .ram0_data_out  (ram0_data_out),
        .ram1_valid_out (ram1_valid_out),
        .ram1_data_out  (ram1_data_out),
        .line_done      (line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Replay index j maps to this pixel of the stored line.
    function automatic int src_idx(input int j);
`ifdef DOG_PP_PAD_EN
        int i = j - PAD;
        if (i < 0) i = 0;
        if (i > LINE_W - 1) i = LINE_W - 1;
        return i;
`else
        return (j > LINE_W - 1) ? LINE_W - 1 : j;
`endif
    endfunction

    // Reference model: accepted pixels in order; complete lines replay front-first.
    logic [7:0] pxq[$];
    int  cyc           = 0;
    bit  mon_en        = 1'b0;
    int  wr_cnt        = 0;
    int  pending       = 0;
    int  exp_bank      = 0;
    int  beat_cnt      = 0;
    int  done_cnt      = 0;
    int  bp_cycles     = 0;
    int  complete_cyc  = 0;
    int  first_beat_cyc = 0;
    int  first_bank    = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            check("mutex", 32'(ram0_valid_out && ram1_valid_out), 32'd0);
            if (!ram0_valid_out) check("d0_idle_zero", 32'(ram0_data_out), 32'd0);
            if (!ram1_valid_out) check("d1_idle_zero", 32'(ram1_data_out), 32'd0);
            if (ram0_valid_out || ram1_valid_out) begin
                if (beat_cnt == 0) begin
                    first_beat_cyc = cyc;
                    first_bank     = int'(ram1_valid_out);
                end
                check("beat_bank", 32'(ram1_valid_out), 32'(exp_bank));
                if (pending == 0 || pxq.size() < LINE_W)
                    check("beat_unexpected", 32'(ram1_valid_out || ram0_valid_out), 32'd0);
                else
                    check("beat_data", 32'(ram1_valid_out ? ram1_data_out : ram0_data_out),
                          32'(pxq[src_idx(beat_cnt)]));
                beat_cnt++;
            end
            if (line_done) begin
                check("line_beats", 32'(beat_cnt), 32'(N));
                check("line_done_pos", 32'(cyc - first_beat_cyc), 32'(N));
                if (pxq.size() >= LINE_W)
                    for (int k = 0; k < LINE_W; k++) void'(pxq.pop_front());
                pending--;
                exp_bank ^= 1;
                beat_cnt = 0;
                done_cnt++;
            end
            check("wr_ready", 32'(wr_ready), 32'(pending < 2));
            if (!wr_ready) bp_cycles++;
            if (start) begin
                pxq.delete();
                wr_cnt   = 0;
                pending  = 0;
                exp_bank = 0;
                beat_cnt = 0;
            end else if (wr_valid && wr_ready) begin
                pxq.push_back(wr_data);
                wr_cnt++;
                if (wr_cnt == LINE_W) begin
                    wr_cnt       = 0;
                    pending++;
                    complete_cyc = cyc;
                end
            end
        end
    end

    task automatic write_px(input logic [7:0] d);
        logic acc   = 1'b0;
        int   tries = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!acc && tries < 3000) begin
            @(negedge clk);
            acc = wr_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) check("wr_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int t = 0;
        while (done_cnt < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("wait_done", 32'(done_cnt), 32'(target));
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int base;
        int t;
        rst_n    = 1'b1;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Reset / idle: ready high, everything else quiet.
        repeat (100) begin
            @(negedge clk);
            check("idle_outputs",
                  32'({wr_ready, ram0_valid_out, ram1_valid_out, line_done, ram0_data_out, ram1_data_out}),
                  32'h8_0000);
        end

        // Single line 0..255 replayed from bank 0.
        @(posedge clk);
        #1;
        base = done_cnt;
        for (int i = 0; i < LINE_W; i++) write_px(8'(i));
        idle(1);
        wait_done(base + 1, 2000);
        check("first_beat_latency", 32'(first_beat_cyc - complete_cyc), 32'd3);
        check("single_line_bank", 32'(first_bank), 32'd0);

        // Ping-pong: three continuous lines, replay banks 0/1/0, backpressure expected.
        start_pulse();
        idle(2);
        base      = done_cnt;
        bp_cycles = 0;
        for (int l = 0; l < 3; l++)
            for (int a = 0; a < LINE_W; a++) write_px(8'(l * 10 + (a & 7)));
        idle(1);
        wait_done(base + 3, 4000);
        check("pp_backpressure_seen", 32'(bp_cycles > 0), 32'd1);
        check("pp_last_bank", 32'(first_bank), 32'd0);

        // Random valid gaps and data over 20 lines.
        base = done_cnt;
        for (int l = 0; l < 20; l++)
            for (int a = 0; a < LINE_W; a++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                write_px(8'($urandom));
            end
        idle(1);
        wait_done(base + 20, 20000);

        // start during replay beat 100 aborts the line; the next line replays from bank 0.
        base = done_cnt;
        for (int a = 0; a < LINE_W; a++) write_px(8'($urandom));
        idle(1);
        t = 0;
        while (beat_cnt < 100 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("reach_beat100", 32'(beat_cnt), 32'd100);
        start_pulse();
        @(negedge clk);
        check("after_start_outputs",
              32'({wr_ready, ram0_valid_out, ram1_valid_out, line_done, ram0_data_out, ram1_data_out}),
              32'h8_0000);
        @(posedge clk);
        #1;
        for (int a = 0; a < LINE_W; a++) write_px(8'(255 - a));
        idle(1);
        wait_done(base + 1, 2000);
        check("restart_bank0", 32'(first_bank), 32'd0);

        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
